// File: rtl/sp_writeback_arbiter.sv
// sp_writeback_arbiter: round-robin SPR result arbiter with output stage, broadcast and owner-checked SPR write port
module sp_writeback_arbiter #(
    parameter int UNITS       = 3,
    parameter int RS_ID_WIDTH = 5
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [UNITS-1:0]                  unit_valid,
    output logic [UNITS-1:0]                  unit_ready,
    input  logic [UNITS-1:0][9:0]             unit_addr,
    input  logic [UNITS-1:0][31:0]            unit_value,
    input  logic [UNITS-1:0][RS_ID_WIDTH-1:0] unit_rs_id,
    input  logic [9:0]                        update_addr,
    input  logic                              update_enable,
    input  logic [RS_ID_WIDTH-1:0]            update_rs_id,
    output logic                              result_valid,
    input  logic                              result_ready,
    output logic [RS_ID_WIDTH-1:0]            result_rs_id,
    output logic [31:0]                       result_value,
    output logic [9:0]                        write_addr,
    output logic                              write_enable,
    output logic [31:0]                       write_value,
    output logic                              bad_addr_error
);
    localparam int PW = UNITS > 1 ? $clog2(UNITS) : 1;
    logic [PW-1:0] rr_ptr, g;
    logic gnt, complete, stage_free;
    logic [9:0] st_addr;
    logic [31:0] st_value;
    logic [RS_ID_WIDTH-1:0] st_rs_id;
    logic [2:0] own_v, st_hot, up_hot, match;
    logic [2:0][RS_ID_WIDTH-1:0] own_id;
    assign complete   = result_valid & result_ready;
    assign stage_free = !result_valid | complete;
    // one-hot SPR decode, bit order {CTR, LR, XER}
    assign st_hot = {st_addr == 10'd9, st_addr == 10'd8, st_addr == 10'd1};
    assign up_hot = {update_addr == 10'd9, update_addr == 10'd8, update_addr == 10'd1};
    always_comb begin
        int j;
        j   = 0;
        gnt = 1'b0;
        g   = '0;
        for (int k = UNITS - 1; k >= 0; k--) begin
            j = (int'(rr_ptr) + k) % UNITS;
            if (unit_valid[j]) begin
                gnt = 1'b1;
                g   = PW'(j);
            end
        end
        gnt        = gnt & stage_free & !rst;
        unit_ready = gnt ? UNITS'(1) << g : '0;
    end
    always_comb begin
        for (int k = 0; k < 3; k++)
            match[k] = own_id[k] == st_rs_id;
    end
    assign write_enable   = complete & |(st_hot & own_v & match);
    assign bad_addr_error = complete & ~|st_hot;
    assign write_addr     = result_valid ? st_addr : '0;
    assign write_value    = result_valid ? st_value : '0;
    assign result_value   = result_valid ? st_value : '0;
    assign result_rs_id   = result_valid ? st_rs_id : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            result_valid <= 1'b0;
            st_addr      <= '0;
            st_value     <= '0;
            st_rs_id     <= '0;
            rr_ptr       <= '0;
        end else if (gnt) begin
            result_valid <= 1'b1;
            st_addr      <= unit_addr[g];
            st_value     <= unit_value[g];
            st_rs_id     <= unit_rs_id[g];
            rr_ptr       <= (g == PW'(UNITS - 1)) ? '0 : g + 1'b1;
        end else if (complete) begin
            result_valid <= 1'b0;
        end
    end
    // a same-cycle snoop update reassigns the SPR and outranks our write clearing it
    always_ff @(posedge clk) begin
        if (rst) begin
            own_v  <= '0;
            own_id <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (update_enable && up_hot[k]) begin
                    own_v[k]  <= 1'b1;
                    own_id[k] <= update_rs_id;
                end else if (write_enable && st_hot[k]) begin
                    own_v[k] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_sp_writeback_arbiter.sv
// tb_sp_writeback_arbiter: directed self-checking bench for sp_writeback_arbiter
module tb_sp_writeback_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic [2:0] unit_valid, unit_ready;
    logic [2:0][9:0] unit_addr;
    logic [2:0][31:0] unit_value;
    logic [2:0][4:0] unit_rs_id;
    logic [9:0] update_addr;
    logic update_enable;
    logic [4:0] update_rs_id;
    logic result_valid, result_ready;
    logic [4:0] result_rs_id;
    logic [31:0] result_value;
    logic [9:0] write_addr;
    logic write_enable;
    logic [31:0] write_value;
    logic bad_addr_error;
    int n_chk = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    sp_writeback_arbiter #(.UNITS(3), .RS_ID_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .unit_valid(unit_valid), .unit_ready(unit_ready), .unit_addr(unit_addr),
        .unit_value(unit_value), .unit_rs_id(unit_rs_id),
        .update_addr(update_addr), .update_enable(update_enable), .update_rs_id(update_rs_id),
        .result_valid(result_valid), .result_ready(result_ready), .result_rs_id(result_rs_id),
        .result_value(result_value), .write_addr(write_addr), .write_enable(write_enable),
        .write_value(write_value), .bad_addr_error(bad_addr_error)
    );
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic present(input int u, input logic [9:0] a, input logic [31:0] v, input logic [4:0] id);
        unit_valid[u] = 1'b1;
        unit_addr[u]  = a;
        unit_value[u] = v;
        unit_rs_id[u] = id;
    endtask
    task automatic upd(input logic [9:0] a, input logic [4:0] id);
        update_enable = 1'b1;
        update_addr   = a;
        update_rs_id  = id;
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        unit_valid = '0;
        update_enable = 1'b0;
        result_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask
    initial begin
        rst = 1'b1;
        unit_valid = '0;
        unit_addr = '0;
        unit_value = '0;
        unit_rs_id = '0;
        update_addr = '0;
        update_enable = 1'b0;
        update_rs_id = '0;
        result_ready = 1'b0;
        do_reset();
        #1;
        check("rst_rv", result_valid, 0);
        check("rst_we", write_enable, 0);
        check("rst_wa", write_addr, 0);
        check("rst_bad", bad_addr_error, 0);
        check("rst_ready", unit_ready, 0);
        // basic LR write
        upd(10'd8, 5'd3);
        present(1, 10'd8, 32'hDEADBEEF, 5'd3);
        #1 check("t1_ready", unit_ready, 3'b010);
        @(negedge clk);
        update_enable = 1'b0;
        unit_valid = '0;
        #1;
        check("t1_rv", result_valid, 1);
        check("t1_we", write_enable, 1);
        check("t1_wa", write_addr, 8);
        check("t1_wv", write_value, 32'hDEADBEEF);
        check("t1_rs", result_rs_id, 3);
        @(negedge clk);
        present(1, 10'd8, 32'h1, 5'd3);
        #1;
        check("t1_idle_rv", result_valid, 0);
        check("t1_idle_we", write_enable, 0);
        @(negedge clk);
        unit_valid = '0;
        #1;
        check("t1_cleared_rv", result_valid, 1);
        check("t1_cleared_we", write_enable, 0);
        // round robin, back to back
        do_reset();
        present(0, 10'd1, 32'h10, 5'd10);
        present(1, 10'd1, 32'h11, 5'd11);
        present(2, 10'd1, 32'h12, 5'd12);
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            #1 check("t2_ready", unit_ready, 32'(1 << (c % 3)));
            if (c > 0) begin
                check("t2_rv", result_valid, 1);
                check("t2_rs", result_rs_id, 32'(10 + (c - 1) % 3));
            end
        end
        unit_valid = '0;
        // stall with full stage
        do_reset();
        upd(10'd1, 5'd5);
        present(0, 10'd1, 32'h111, 5'd5);
        present(1, 10'd1, 32'h222, 5'd6);
        result_ready = 1'b0;
        #1 check("t3_ready0", unit_ready, 3'b001);
        @(negedge clk);
        update_enable = 1'b0;
        unit_valid[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_stall_ready", unit_ready, 0);
            check("t3_stall_rv", result_valid, 1);
            check("t3_stall_val", result_value, 32'h111);
            check("t3_stall_we", write_enable, 0);
            @(negedge clk);
        end
        result_ready = 1'b1;
        #1;
        check("t3_we", write_enable, 1);
        check("t3_wv", write_value, 32'h111);
        check("t3_ready1", unit_ready, 3'b010);
        @(negedge clk);
        unit_valid = '0;
        #1;
        check("t3_next_rv", result_valid, 1);
        check("t3_next_val", result_value, 32'h222);
        check("t3_next_rs", result_rs_id, 6);
        check("t3_next_we", write_enable, 0);
        @(negedge clk);
        #1 check("t3_empty", result_valid, 0);
        // CTR ownership moves from rs 4 to rs 7
        upd(10'd9, 5'd4);
        @(negedge clk);
        upd(10'd9, 5'd7);
        @(negedge clk);
        update_enable = 1'b0;
        present(0, 10'd9, 32'h44, 5'd4);
        #1 check("t4_ready", unit_ready, 3'b001);
        @(negedge clk);
        unit_valid = '0;
        #1;
        check("t4_stale_rv", result_valid, 1);
        check("t4_stale_rs", result_rs_id, 4);
        check("t4_stale_we", write_enable, 0);
        check("t4_stale_bad", bad_addr_error, 0);
        @(negedge clk);
        present(0, 10'd9, 32'h77, 5'd7);
        @(negedge clk);
        unit_valid = '0;
        #1;
        check("t4_we", write_enable, 1);
        check("t4_wa", write_addr, 9);
        check("t4_wv", write_value, 32'h77);
        // illegal SPR number
        @(negedge clk);
        present(2, 10'd5, 32'h55, 5'd1);
        @(negedge clk);
        unit_valid = '0;
        #1;
        check("t5_rv", result_valid, 1);
        check("t5_wa", write_addr, 5);
        check("t5_we", write_enable, 0);
        check("t5_bad", bad_addr_error, 1);
        @(negedge clk);
        #1;
        check("t5_bad_off", bad_addr_error, 0);
        check("t5_rv_off", result_valid, 0);
        // write and update collide on XER
        upd(10'd1, 5'd2);
        @(negedge clk);
        update_enable = 1'b0;
        present(0, 10'd1, 32'h66, 5'd2);
        @(negedge clk);
        unit_valid = '0;
        upd(10'd1, 5'd6);
        #1 check("t6_we", write_enable, 1);
        @(negedge clk);
        update_enable = 1'b0;
        present(0, 10'd1, 32'h67, 5'd2);
        @(negedge clk);
        present(0, 10'd1, 32'h68, 5'd6);
        #1 check("t6_old_we", write_enable, 0);
        @(negedge clk);
        unit_valid = '0;
        #1;
        check("t6_new_we", write_enable, 1);
        check("t6_new_wv", write_value, 32'h68);
        // reset mid-operation
        @(negedge clk);
        present(0, 10'd8, 32'h88, 5'd3);
        #1 check("t7_ready", unit_ready, 3'b001);
        @(negedge clk);
        rst = 1'b1;
        #1 check("t7_rst_ready", unit_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t7_rv", result_valid, 0);
        check("t7_we", write_enable, 0);
        check("t7_ready_after", unit_ready, 3'b001);
        unit_valid = '0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
